// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Holds the FSM state encoding and the load-use hazard compare.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        FLUSH2 = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // x0 is hardwired to zero, so a load targeting it can never create a hazard.
    function automatic logic is_load_use(
        input logic       mem_r,
        input logic [4:0] wr_addr,
        input logic [4:0] rs1_addr,
        input logic       use_rs1,
        input logic [4:0] rs2_addr,
        input logic       use_rs2
    );
        return mem_r && (wr_addr != REG_ZERO) &&
               ((use_rs1 && (wr_addr == rs1_addr)) ||
                (use_rs2 && (wr_addr == rs2_addr)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard inputs and the stall/flush strobes returned to the pipe.
// The pipeline drives the master side; hazard_ctrl sits on the slave side.
interface hazard_ctrl_if;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       ex_mem_r;
    logic [4:0] ex_wr_addr;
    logic       ex_redirect;
    logic       imem_wait;
    logic       dmem_wait;

    logic       pc_write;
    logic       IF_ID_stall;
    logic       IF_ID_flush;
    logic       ID_EX_stall;
    logic       ID_EX_flush;
    logic       EX_MEM_stall;
    logic       MEM_WB_stall;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
               ex_mem_r, ex_wr_addr, ex_redirect, imem_wait, dmem_wait,
        input  pc_write, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_stall
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_use_rs1, id_use_rs2,
               ex_mem_r, ex_wr_addr, ex_redirect, imem_wait, dmem_wait,
        output pc_write, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
               EX_MEM_stall, MEM_WB_stall
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear takes precedence over a same-cycle increment; the count sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central 5-stage pipeline sequencer: load-use bubble, two-cycle redirect flush,
// memory-wait freeze, and saturating stall/flush event counters.
//
//   state  | meaning
//   RUN    | normal flow; a load-use hazard inserts one bubble
//   BUBBLE | bubble is in EX; load_use is ignored, pipe advances
//   FLUSH2 | second flush cycle after a taken branch/jump
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     hz,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    hz_state_t state;
    hz_state_t state_nxt;

    logic freeze;
    logic load_use;
    logic redirect_taken;

    logic pc_write;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_stall;

    assign freeze   = hz.imem_wait | hz.dmem_wait;
    assign load_use = is_load_use(hz.ex_mem_r, hz.ex_wr_addr,
                                  hz.id_rs1_addr, hz.id_use_rs1,
                                  hz.id_rs2_addr, hz.id_use_rs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority: reset, freeze, redirect, pending second flush, load-use.
    always_comb begin
        state_nxt      = state;
        pc_write       = 1'b0;
        if_id_stall    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_stall    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_stall   = 1'b0;
        mem_wb_stall   = 1'b0;
        redirect_taken = 1'b0;

        if (rst) begin
            state_nxt = RUN;
        end else if (freeze) begin
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_stall = 1'b1;
        end else if (hz.ex_redirect) begin
            pc_write       = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            redirect_taken = 1'b1;
            state_nxt      = FLUSH2;
        end else begin
            case (state)
                FLUSH2: begin
                    pc_write    = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_nxt   = RUN;
                end
                BUBBLE: begin
                    pc_write  = 1'b1;
                    state_nxt = RUN;
                end
                default: begin
                    if (load_use) begin
                        if_id_stall = 1'b1;
                        id_ex_stall = 1'b1;
                        state_nxt   = BUBBLE;
                    end else begin
                        pc_write  = 1'b1;
                        state_nxt = RUN;
                    end
                end
            endcase
        end
    end

    assign hz.pc_write     = pc_write;
    assign hz.IF_ID_stall  = if_id_stall;
    assign hz.IF_ID_flush  = if_id_flush;
    assign hz.ID_EX_stall  = id_ex_stall;
    assign hz.ID_EX_flush  = id_ex_flush;
    assign hz.EX_MEM_stall = ex_mem_stall;
    assign hz.MEM_WB_stall = mem_wb_stall;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (~pc_write),
        .q   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (redirect_taken),
        .q   (flush_cnt)
    );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Owns every stall/flush strobe for the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers, plus the PC write enable.
- Detects load-use hazards, sequences the two-cycle branch/jump flush, and freezes the whole pipe while the instruction or data memory is busy.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset (sampled on posedge clk only)
id_rs1_addr  in  5  rs1 index of instruction in ID
id_rs2_addr  in  5  rs2 index of instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_mem_r  in  1  instruction in EX is a load
ex_wr_addr  in  5  rd of instruction in EX
ex_redirect  in  1  EX resolved taken branch/jump; PC must load target this cycle
imem_wait  in  1  instruction memory not ready
dmem_wait  in  1  data memory not ready
cnt_clr  in  1  clear both performance counters
pc_write  out  1  PC register load enable
IF_ID_stall  out  1  hold IF_ID
IF_ID_flush  out  1  zero IF_ID
ID_EX_stall  out  1  insert bubble in ID_EX (control fields zeroed)
ID_EX_flush  out  1  zero ID_EX entirely
EX_MEM_stall  out  1  hold EX_MEM
MEM_WB_stall  out  1  hold MEM_WB
stall_cnt  out  CNT_W  cycles with pc_write=0 since clear
flush_cnt  out  CNT_W  redirect events since clear

Behaviour:
- FSM states: RUN, BUBBLE, FLUSH2. State and counters are registered. All strobe outputs are combinational from state and current inputs.
- Reset behaviour:
  - While rst=1: all strobes 0, pc_write 0.
  - At the clock edge where rst=1: state goes to RUN and both counters go to 0.
- Reset mid-sequence (BUBBLE or FLUSH2) aborts it; no residual flush is issued after reset.
- freeze = imem_wait | dmem_wait.
- load_use = ex_mem_r & (ex_wr_addr != 0) & ((id_use_rs1 & ex_wr_addr == id_rs1_addr) | (id_use_rs2 & ex_wr_addr == id_rs2_addr)).
- Priority: freeze > ex_redirect > FLUSH2 second flush > load_use.
- Freeze, in any state:
  - pc_write = 0; all four *_stall = 1; both flushes = 0.
  - State holds.
  - EX is held, so ex_redirect stays stable and is acted on in the first cycle after the freeze ends.
- ex_redirect (no freeze):
  - pc_write = 1; IF_ID_flush = 1; ID_EX_flush = 1.
  - Next state is FLUSH2, whatever the current state.
  - flush_cnt increments.
- FLUSH2 (no freeze, no redirect):
  - IF_ID_flush = 1; ID_EX_flush = 1; pc_write = 1.
  - Next state is RUN.
  - A redirect in FLUSH2 restarts the sequence: stay in FLUSH2 for one more flush cycle.
- load_use in RUN (no freeze, no redirect):
  - pc_write = 0; IF_ID_stall = 1; ID_EX_stall = 1.
  - Next state is BUBBLE.
  - Latency: exactly one bubble per load-use pair.
- BUBBLE: all strobes 0, pc_write = 1, next state RUN. load_use is ignored in BUBBLE, since the bubble in EX has mem_r = 0.
- RUN with no event: pc_write = 1, all other strobes 0.
- Counters:
  - stall_cnt increments in every non-reset cycle with pc_write = 0.
  - Both counters saturate at all-ones and do not wrap.
  - cnt_clr zeroes both and wins over a same-cycle increment.
- Hazard on x0 never stalls.
- A load with rd matching a register the ID instruction does not read never stalls.

Decomposition:
- Shared package hazard_pkg holds:
  - hz_state_t enum {RUN, BUBBLE, FLUSH2};
  - REG_ZERO constant 5'd0.
- One sub-module, sat_counter (params W; ports clk, rst, clr, inc, q), instantiated twice.

Test Plan:
- Reset then idle: rst high 2 cycles → all strobes 0 and pc_write 0 during reset; after release pc_write = 1, counters = 0.
- Load-use: ex_mem_r = 1, ex_wr_addr = 5, id_rs2_addr = 5, id_use_rs2 = 1 → one cycle with pc_write = 0, IF_ID_stall = 1, ID_EX_stall = 1; next cycle all clear; stall_cnt = 1.
- Load to x0: ex_wr_addr = 0, id_rs1_addr = 0, id_use_rs1 = 1 → no stall, stall_cnt unchanged.
- Redirect: ex_redirect pulse one cycle → IF_ID_flush and ID_EX_flush high exactly two consecutive cycles, pc_write = 1 both cycles, flush_cnt = 1.
- Redirect colliding with load_use same cycle → flush sequence only, no stall; redirect again in FLUSH2 → flushes extend to 3 cycles total, flush_cnt = 2.
- Freeze mid-FLUSH2: dmem_wait high 3 cycles during second flush cycle → all *_stall = 1, flushes 0, pc_write 0 for 3 cycles, stall_cnt += 3; second flush issued the cycle after wait drops.
- Saturation: CNT_W = 4, hold imem_wait 20 cycles → stall_cnt = 15; pulse cnt_clr with wait still high → 0.
